// File: rtl/fp_mult_axis_pipe.sv
// Pipelined floating-point multiplier with AXI4-Stream operand/result channels.
// Three register stages: unpack+multiply, normalise, round+pack.
//
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   s_axis_a_* / s_axis_b_*          operand streams {sign, exp, frac}
//   m_axis_result_tvalid/tready      result handshake
//   m_axis_result_tdata              product A*B
//   m_axis_result_tuser              {invalid, overflow, underflow}
module fp_mult_axis_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     s_axis_a_tvalid,
    output logic                     s_axis_a_tready,
    input  logic [EXP_W+MAN_W:0]     s_axis_a_tdata,
    input  logic                     s_axis_b_tvalid,
    output logic                     s_axis_b_tready,
    input  logic [EXP_W+MAN_W:0]     s_axis_b_tdata,
    output logic                     m_axis_result_tvalid,
    input  logic                     m_axis_result_tready,
    output logic [EXP_W+MAN_W:0]     m_axis_result_tdata,
    output logic [2:0]               m_axis_result_tuser
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    logic accept;

    assign en = ~(m_axis_result_tvalid & ~m_axis_result_tready);
    assign s_axis_a_tready = en;
    assign s_axis_b_tready = en;
    assign accept = s_axis_a_tvalid & s_axis_b_tvalid & en;

    // ---------------- stage 1: unpack, classify, multiply
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;

    assign {sa, ea, fa} = s_axis_a_tdata;
    assign {sb, eb, fb} = s_axis_b_tdata;

    // exponent 0 covers subnormals too: they are flushed to zero on input
    logic a_zero, a_inf, a_nan, a_snan;
    logic b_zero, b_inf, b_nan, b_snan;

    assign a_zero = (ea == '0);
    assign a_inf  = (ea == EMAX) && (fa == '0);
    assign a_nan  = (ea == EMAX) && (fa != '0);
    assign a_snan = a_nan & ~fa[MAN_W-1];
    assign b_zero = (eb == '0);
    assign b_inf  = (eb == EMAX) && (fb == '0);
    assign b_nan  = (eb == EMAX) && (fb != '0);
    assign b_snan = b_nan & ~fb[MAN_W-1];

    logic                 c_sign;
    logic                 c_spec;
    logic [W-1:0]         c_sdata;
    logic [2:0]           c_sflags;
    logic signed [XW-1:0] c_exp;
    logic [PW-1:0]        c_prod;
    logic                 inf_zero;

    assign inf_zero = (a_inf & b_zero) | (a_zero & b_inf);

    always_comb begin
        c_sign   = sa ^ sb;
        c_spec   = 1'b1;
        c_sdata  = QNAN;
        c_sflags = 3'b000;
        if (a_nan | b_nan | inf_zero) begin
            c_sflags = {inf_zero | a_snan | b_snan, 2'b00};
        end else if (a_inf | b_inf) begin
            c_sdata = {c_sign, EMAX, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            c_sdata = {c_sign, {(W-1){1'b0}}};
        end else begin
            c_spec = 1'b0;
        end
    end

    assign c_exp = $signed({2'b00, ea}) + $signed({2'b00, eb})
                 - $signed(XW'(BIAS));
    assign c_prod = PW'({1'b1, fa}) * PW'({1'b1, fb});

    logic                 s1_valid, s1_sign, s1_spec;
    logic [W-1:0]         s1_sdata;
    logic [2:0]           s1_sflags;
    logic signed [XW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_spec   <= 1'b0;
            s1_sdata  <= '0;
            s1_sflags <= '0;
            s1_exp    <= '0;
            s1_prod   <= '0;
        end else if (en) begin
            s1_valid  <= accept;
            s1_sign   <= c_sign;
            s1_spec   <= c_spec;
            s1_sdata  <= c_sdata;
            s1_sflags <= c_sflags;
            s1_exp    <= c_exp;
            s1_prod   <= c_prod;
        end
    end

    // ---------------- stage 2: normalise, guard + sticky
    // product of two [1,2) significands lies in [1,4)
    logic [MAN_W-1:0]     n_frac;
    logic                 n_g, n_s;
    logic signed [XW-1:0] n_exp;

    always_comb begin
        if (s1_prod[PW-1]) begin
            n_frac = s1_prod[PW-2 -: MAN_W];
            n_g    = s1_prod[MAN_W];
            n_s    = |s1_prod[MAN_W-1:0];
            n_exp  = s1_exp + $signed(XW'(1));
        end else begin
            n_frac = s1_prod[PW-3 -: MAN_W];
            n_g    = s1_prod[MAN_W-1];
            n_s    = |s1_prod[MAN_W-2:0];
            n_exp  = s1_exp;
        end
    end

    logic                 s2_valid, s2_sign, s2_spec, s2_g, s2_s;
    logic [W-1:0]         s2_sdata;
    logic [2:0]           s2_sflags;
    logic signed [XW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_frac;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_spec   <= 1'b0;
            s2_g      <= 1'b0;
            s2_s      <= 1'b0;
            s2_sdata  <= '0;
            s2_sflags <= '0;
            s2_exp    <= '0;
            s2_frac   <= '0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_spec   <= s1_spec;
            s2_g      <= n_g;
            s2_s      <= n_s;
            s2_sdata  <= s1_sdata;
            s2_sflags <= s1_sflags;
            s2_exp    <= n_exp;
            s2_frac   <= n_frac;
        end
    end

    // ---------------- stage 3: round to nearest even, range check, pack
    logic                 r_inc;
    logic [MAN_W:0]       r_sum;
    logic signed [XW-1:0] r_exp;
    logic [W-1:0]         r_data;
    logic [2:0]           r_user;

    assign r_inc = s2_g & (s2_s | s2_frac[0]);
    assign r_sum = {1'b0, s2_frac} + {{MAN_W{1'b0}}, r_inc};
    // carry out leaves r_sum[MAN_W-1:0] all zero: mantissa becomes 1.0
    assign r_exp = s2_exp + $signed({{(XW-1){1'b0}}, r_sum[MAN_W]});

    always_comb begin
        r_data = {s2_sign, r_exp[EXP_W-1:0], r_sum[MAN_W-1:0]};
        r_user = 3'b000;
        if (s2_spec) begin
            r_data = s2_sdata;
            r_user = s2_sflags;
        end else if (r_exp >= $signed({2'b00, EMAX})) begin
            r_data = {s2_sign, EMAX, {MAN_W{1'b0}}};
            r_user = 3'b010;
        end else if (r_exp <= $signed(XW'(0))) begin
            r_data = {s2_sign, {(W-1){1'b0}}};
            r_user = 3'b001;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= '0;
            m_axis_result_tuser  <= '0;
        end else if (en) begin
            m_axis_result_tvalid <= s2_valid;
            m_axis_result_tdata  <= r_data;
            m_axis_result_tuser  <= r_user;
        end
    end

endmodule

// File: tb/tb_fp_mult_axis_pipe.sv
// Testbench for fp_mult_axis_pipe (EXP_W=8, MAN_W=23).
// Directed steps plus randomized beats against an arithmetic reference model.
module tb_fp_mult_axis_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_data, b_data;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [2:0]  r_user;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_out   = 0;
    bit bp_mode = 1'b0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    fp_mult_axis_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (a_ready),
        .s_axis_a_tdata       (a_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tready      (b_ready),
        .s_axis_b_tdata       (b_data),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tready (r_ready),
        .m_axis_result_tdata  (r_data),
        .m_axis_result_tuser  (r_user)
    );

    task automatic chk(input string tag, input logic [34:0] obs,
                       input logic [34:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the
    // discarded remainder with half an ulp. Returns {flags, word}.
    function automatic logic [34:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        logic s = a[31] ^ b[31];
        bit za = (ea == 0);
        bit zb = (eb == 0);
        bit ia = (ea == 255) && (a[22:0] == 0);
        bit ib = (eb == 255) && (b[22:0] == 0);
        bit na = (ea == 255) && (a[22:0] != 0);
        bit nb = (eb == 255) && (b[22:0] != 0);
        bit sna = na && !a[22];
        bit snb = nb && !b[22];
        bit iz = (ia && zb) || (za && ib);
        longint unsigned ma, mb, p, q, rem, half;
        int e, sh;
        if (na || nb || iz)
            return {iz || sna || snb, 2'b00, 32'h7FC00000};
        if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
        if (za || zb) return {3'b000, s, 31'h0};
        ma = (64'd1 << 23) + longint'(a[22:0]);
        mb = (64'd1 << 23) + longint'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] sp[6] = '{32'h00000000, 32'h7F800000, 32'h7FC00000,
                               32'h7F800001, 32'h00000001, 32'h7F7FFFFF};
        int k = int'($urandom_range(0, 9));
        logic s = 1'($urandom);
        logic [31:0] pick;
        if (k == 0) return $urandom;
        if (k == 1) begin
            pick = sp[$urandom_range(0, 5)];
            return {s, pick[30:0]};
        end
        if (k == 2)
            return {s, 8'($urandom_range(64, 190)),
                    23'($urandom) & 23'h7FF000};
        return {s, 8'($urandom_range(64, 190)), 23'($urandom)};
    endfunction

    // Scoreboard: push model result on every accepted beat, compare
    // every transferred result in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && b_valid && a_ready) begin
                exp_q.push_back(ref_mul(a_data, b_data));
                n_acc++;
            end
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0)
                    chk("spurious_beat", 35'(exp_q.size()), 35'd1);
                else
                    chk("result", {r_user, r_data}, exp_q.pop_front());
                n_out++;
            end
            if (a_ready !== b_ready)
                chk("ready_match", b_ready, a_ready);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_ready) begin
                @(posedge clk);
                #1;
                a_valid = 1'b0;
                b_valid = 1'b0;
                if (bp_mode) r_ready = ($urandom_range(0, 3) != 0);
                return;
            end
            @(posedge clk);
            #1;
            if (bp_mode) r_ready = ($urandom_range(0, 3) != 0);
        end
        chk("send_timeout", a_ready, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic drain();
        r_ready = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 35'(exp_q.size()), 35'd0);
    endtask

    task automatic run_one(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [34:0] expv);
        send(a, b);
        for (int i = 0; i < 20 && !r_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, {r_user, r_data}, expv);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_check(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic [34:0] expv);
        @(posedge clk);
        #1;
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, a_ready, 1'b1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk({tag, "_edge1"}, r_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_edge2"}, r_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_edge3_valid"}, r_valid, 1'b1);
        chk({tag, "_edge3_data"}, {r_user, r_data}, expv);
    endtask

    initial begin
        logic [34:0] held;
        int acc0, out0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        r_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", r_valid, 1'b0);
        chk("reset_data", r_data, 32'h0);
        chk("reset_user", r_user, 3'b000);
        #2 rst_n = 1'b1;

        lat_check("latency", 32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});

        run_one("tie_even", 32'h3F800800, 32'h3F800800, {3'b000, 32'h3F801000});
        run_one("round_up", 32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002});
        run_one("overflow", 32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000});
        run_one("underflow", 32'h00800000, 32'h00800000, {3'b001, 32'h00000000});
        run_one("inf_x_zero", 32'h7F800000, 32'h80000000, {3'b100, 32'h7FC00000});
        run_one("qnan_in", 32'h7FC00001, 32'h3F800000, {3'b000, 32'h7FC00000});
        run_one("snan_in", 32'h7F800001, 32'h3F800000, {3'b100, 32'h7FC00000});
        run_one("inf_x_neg", 32'h7F800000, 32'hC0000000, {3'b000, 32'hFF800000});
        run_one("daz", 32'h00000001, 32'hC0000000, {3'b000, 32'h80000000});
        run_one("round_carry", 32'h3FFFFFFF, 32'h3FFFFFFF, {3'b000, 32'h407FFFFE});

        // burst of 8 with a 5-cycle consumer stall after beat 4
        out0 = n_out;
        for (int i = 0; i < 4; i++) send(rnd_op(), rnd_op());
        r_ready = 1'b0;
        chk("stall_valid", r_valid, 1'b1);
        held = {r_user, r_data};
        a_data  = rnd_op();
        b_data  = rnd_op();
        a_valid = 1'b1;
        b_valid = 1'b1;
        acc0 = n_acc;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_hold", {r_user, r_data}, held);
            chk("stall_ready", a_ready, 1'b0);
        end
        chk("stall_no_accept", 35'(n_acc), 35'(acc0));
        r_ready = 1'b1;
        send(a_data, b_data);
        for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
        drain();
        chk("burst_count", 35'(n_out - out0), 35'd8);

        // lone A valid: held, not consumed
        acc0 = n_acc;
        a_data  = 32'h40400000;
        a_valid = 1'b1;
        b_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("lone_a_no_accept", 35'(n_acc), 35'(acc0));
        chk("lone_a_ready", a_ready, 1'b1);
        run_one("lone_a_pair", a_data, 32'h40800000, {3'b000, 32'h41400000});

        // reset with beats in flight
        for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", r_valid, 1'b0);
        chk("rst_mid_data", r_data, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        lat_check("post_reset", 32'hC0A00000, 32'h3E800000, {3'b000, 32'hBFA00000});

        // randomized beats with random consumer backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 300; i++) send(rnd_op(), rnd_op());
        bp_mode = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
